// File: rtl/ls_exec_unit_if.sv
// Dispatch/CDB signal bundle between the load/store reservation station and ls_exec_unit.
// The station (or a bench) takes the master side; the execution unit takes the slave side.
interface ls_exec_unit_if;
    logic        despacho;
    logic [3:0]  ID_in;
    logic [15:0] Valor1;
    logic [15:0] Valor2;
    logic [15:0] Valor3;
    logic [5:0]  OP_Rd;
    logic [9:0]  clockInstr_in;
    logic        cdb_grant;
    logic        busy;
    logic        confirma;
    logic [3:0]  ID_out;
    logic        cdb_req;
    logic [19:0] cdb_data;
    logic [2:0]  Rd_out;
    logic [9:0]  clockInstr_out;

    modport master (
        output despacho, ID_in, Valor1, Valor2, Valor3, OP_Rd, clockInstr_in, cdb_grant,
        input  busy, confirma, ID_out, cdb_req, cdb_data, Rd_out, clockInstr_out
    );

    modport slave (
        input  despacho, ID_in, Valor1, Valor2, Valor3, OP_Rd, clockInstr_in, cdb_grant,
        output busy, confirma, ID_out, cdb_req, cdb_data, Rd_out, clockInstr_out
    );
endinterface

// File: rtl/ls_exec_unit.sv
// Load/store execution unit: effective-address calc, internal data memory, CDB request for loads.
// Optional last-store forwarding to loads is enabled by defining LS_STORE_FWD_EN.
module ls_exec_unit #(
    parameter int AW      = 8,
    parameter int MEM_LAT = 2
) (
    input  logic         CLK,
    input  logic         CLR,
    ls_exec_unit_if.slave bus
);

    localparam int LAT = (MEM_LAT < 1) ? 1 : MEM_LAT;
    localparam int CW  = (LAT < 2) ? 1 : $clog2(LAT);
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_MEM, S_WB, S_DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [6:0]    r_off;
    logic [15:0]   r_base;
    logic [15:0]   r_wdata;
    logic [2:0]    r_op;
    logic [2:0]    r_rd;
    logic [3:0]    r_id;
    logic [9:0]    r_line;
    logic [15:0]   r_rdata;
    logic          r_busy;
    logic          r_confirma;
    logic          r_cdb_req;
    logic [15:0]   r_mem [2**AW];

    logic [15:0]   w_ea;
    logic [AW-1:0] w_idx;
    logic          w_is_load;
    logic          w_is_store;
    logic          w_mem_we;
    logic          w_fwd_hit;
    logic [15:0]   w_fwd_data;

    // Offset is a 7-bit two's-complement value; the sum wraps at 16 bits.
    assign w_ea       = r_base + {{9{r_off[6]}}, r_off};
    assign w_idx      = w_ea[AW-1:0];
    assign w_is_load  = (r_op == OP_LOAD);
    assign w_is_store = (r_op == OP_STORE);
    assign w_mem_we   = (r_state == S_MEM) && (r_cnt == '0) && w_is_store;

`ifdef LS_STORE_FWD_EN
    logic          r_fwd_valid;
    logic [AW-1:0] r_fwd_idx;
    logic [15:0]   r_fwd_data;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_fwd_valid <= 1'b0;
            r_fwd_idx   <= '0;
            r_fwd_data  <= '0;
        end else if (w_mem_we) begin
            r_fwd_valid <= 1'b1;
            r_fwd_idx   <= w_idx;
            r_fwd_data  <= r_wdata;
        end
    end

    assign w_fwd_hit  = r_fwd_valid && (r_fwd_idx == w_idx);
    assign w_fwd_data = r_fwd_data;
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = '0;
`endif

    // NOTE: the memory array has no reset branch; clearing it would turn the
    // RAM into a huge flop bank, and its contents must survive CLR anyway.
    always_ff @(posedge CLK) begin
        if (w_mem_we) r_mem[w_idx] <= r_wdata;
    end

    // NOTE: all state updates use <= so every register sees pre-edge values,
    // independent of statement order inside the block.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_off      <= '0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_op       <= '0;
            r_rd       <= '0;
            r_id       <= '0;
            r_line     <= '0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_confirma <= 1'b0;
            r_cdb_req  <= 1'b0;
        end else begin
            r_confirma <= 1'b0;
            unique case (r_state)
                S_IDLE: if (bus.despacho) begin
                    r_off   <= bus.Valor1[6:0];
                    r_base  <= bus.Valor2;
                    r_wdata <= bus.Valor3;
                    r_op    <= bus.OP_Rd[2:0];
                    r_rd    <= bus.OP_Rd[5:3];
                    r_id    <= bus.ID_in;
                    r_line  <= bus.clockInstr_in;
                    r_busy  <= 1'b1;
                    r_state <= S_ADDR;
                end
                S_ADDR: begin
                    if (w_is_load && w_fwd_hit) begin
                        r_rdata   <= w_fwd_data;
                        r_cdb_req <= 1'b1;
                        r_state   <= S_WB;
                    end else if (w_is_load || w_is_store) begin
                        r_cnt   <= CNT_INIT;
                        r_state <= S_MEM;
                    end else begin
                        r_confirma <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_MEM: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_is_load) begin
                        r_rdata   <= r_mem[w_idx];
                        r_cdb_req <= 1'b1;
                        r_state   <= S_WB;
                    end else begin
                        r_confirma <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_WB: if (bus.cdb_grant) begin
                    r_cdb_req  <= 1'b0;
                    r_confirma <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.confirma       = r_confirma;
    assign bus.ID_out         = r_id;
    assign bus.cdb_req        = r_cdb_req;
    assign bus.cdb_data       = {r_id, r_rdata};
    assign bus.Rd_out         = r_rd;
    assign bus.clockInstr_out = r_line;

endmodule

// File: tb/tb_ls_exec_unit.sv
// Scoreboard bench for ls_exec_unit: directed ops push expected tags/CDB words; a monitor pops and compares.
// Latency expectations follow LS_STORE_FWD_EN when it is defined for the build.
module tb_ls_exec_unit;

`ifdef LS_STORE_FWD_EN
    localparam int FWD_K = 1;
`else
    localparam int FWD_K = 3;
`endif

    logic clk;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    logic [19:0] exp_cdb[$];
    logic [3:0]  exp_tag[$];

    ls_exec_unit_if bus();

    ls_exec_unit #(.AW(8), .MEM_LAT(2)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented CDB word and every confirma tag against the queues.
    always @(negedge clk) begin
        if (!clr) begin
            if (bus.cdb_req) begin
                if (exp_cdb.size() == 0) begin
                    check("cdb_req_unexpected", 32'(bus.cdb_req), 32'd0);
                end else begin
                    check("cdb_data", 32'(bus.cdb_data), 32'(exp_cdb[0]));
                    if (bus.cdb_grant) void'(exp_cdb.pop_front());
                end
            end
            if (bus.confirma) begin
                if (exp_tag.size() == 0) check("confirma_unexpected", 32'(bus.confirma), 32'd0);
                else check("confirma_tag", 32'(bus.ID_out), 32'(exp_tag.pop_front()));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(bus.busy), 32'd0);
        check({tag, "_confirma"}, 32'(bus.confirma), 32'd0);
        check({tag, "_cdb_req"},  32'(bus.cdb_req), 32'd0);
        check({tag, "_cdb_data"}, 32'(bus.cdb_data), 32'd0);
        check({tag, "_id_out"},   32'(bus.ID_out), 32'd0);
        check({tag, "_rd_out"},   32'(bus.Rd_out), 32'd0);
        check({tag, "_line_out"}, 32'(bus.clockInstr_out), 32'd0);
    endtask

    // Drives an op, returns just after its accept edge E0 (despacho dropped unless hold).
    task automatic issue(input logic [5:0] op_rd, input logic [15:0] v1, input logic [15:0] v2,
                         input logic [15:0] v3, input logic [3:0] id, input logic [9:0] line,
                         input bit hold);
        @(posedge clk); #2;
        bus.OP_Rd = op_rd; bus.Valor1 = v1; bus.Valor2 = v2; bus.Valor3 = v3;
        bus.ID_in = id; bus.clockInstr_in = line; bus.despacho = 1'b1;
        @(posedge clk); #2;
        if (!hold) bus.despacho = 1'b0;
    endtask

    // Counts edges since E0 until cdb_req and confirma appear; -1 means never seen.
    task automatic wait_op(output int k_req, output int k_conf);
        k_req = -1;
        k_conf = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.cdb_req && k_req < 0) k_req = k;
            if (bus.confirma) begin
                k_conf = k;
                break;
            end
        end
    endtask

    task automatic run_load(input string tag, input logic [15:0] v1, input logic [15:0] v2,
                            input logic [3:0] id, input logic [15:0] data, input int k_req_exp);
        int kr, kc;
        exp_tag.push_back(id);
        exp_cdb.push_back({id, data});
        issue(6'b001_011, v1, v2, 16'h0000, id, 10'd100, 1'b0);
        wait_op(kr, kc);
        check({tag, "_req_latency"}, 32'(kr), 32'(k_req_exp));
        check({tag, "_conf_latency"}, 32'(kc), 32'(k_req_exp + 1));
    endtask

    task automatic run_store(input string tag, input logic [15:0] v1, input logic [15:0] v2,
                             input logic [15:0] data, input logic [3:0] id);
        int kr, kc;
        exp_tag.push_back(id);
        issue(6'b000_100, v1, v2, data, id, 10'd200, 1'b0);
        wait_op(kr, kc);
        check({tag, "_no_req"}, 32'(kr), 32'hFFFF_FFFF);
        check({tag, "_conf_latency"}, 32'(kc), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kr, kc;
        clr = 1'b1;
        bus.despacho = 1'b0; bus.ID_in = '0; bus.Valor1 = '0; bus.Valor2 = '0; bus.Valor3 = '0;
        bus.OP_Rd = '0; bus.clockInstr_in = '0; bus.cdb_grant = 1'b1;
        #1;
        check_all_zero("reset");
        @(posedge clk); #2 clr = 1'b0;

        // Store 0xBEEF to 0x10+5 = 0x15, tag 2
        exp_tag.push_back(4'h2);
        issue(6'b000_100, 16'h0005, 16'h0010, 16'hBEEF, 4'h2, 10'd17, 1'b0);
        check("t2_id_out", 32'(bus.ID_out), 32'h2);
        check("t2_line_out", 32'(bus.clockInstr_out), 32'd17);
        wait_op(kr, kc);
        check("t2_no_req", 32'(kr), 32'hFFFF_FFFF);
        check("t2_conf_latency", 32'(kc), 32'd3);

        // Seed mem[0x1F] = 0x1234, then load from 0x20 + (-1) with grant held off
        run_store("t3_seed", 16'h0000, 16'h001F, 16'h1234, 4'h3);
        bus.cdb_grant = 1'b0;
        exp_tag.push_back(4'h5);
        exp_cdb.push_back(20'h51234);
        issue(6'b101_011, 16'h007F, 16'h0020, 16'h0000, 4'h5, 10'd30, 1'b0);
        kr = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.cdb_req) begin
                kr = k;
                break;
            end
        end
        check("t3_req_latency", 32'(kr), 32'(FWD_K));
        check("t3_rd_out", 32'(bus.Rd_out), 32'd5);
        repeat (3) begin
            @(negedge clk);
            check("t3_req_held", 32'(bus.cdb_req), 32'd1);
            check("t3_no_early_confirma", 32'(bus.confirma), 32'd0);
        end
        @(posedge clk); #2 bus.cdb_grant = 1'b1;
        @(negedge clk);
        check("t3_conf_before_grant_edge", 32'(bus.confirma), 32'd0);
        @(negedge clk);
        check("t3_conf_after_grant", 32'(bus.confirma), 32'd1);

        // Store 0x1111 to 0x15 aborted by CLR while in MEM, just before its write edge
        bus.cdb_grant = 1'b0;
        issue(6'b000_100, 16'h0000, 16'h0015, 16'h1111, 4'h6, 10'd40, 1'b0);
        @(posedge clk);
        @(posedge clk); #3;
        check("t1_busy_before_clr", 32'(bus.busy), 32'd1);
        clr = 1'b1;
        #1;
        check_all_zero("t1_clr");
        @(posedge clk); #2 clr = 1'b0;
        bus.cdb_grant = 1'b1;
        run_load("t1_mem_kept", 16'h0000, 16'h0015, 4'h7, 16'hBEEF, 3);

        // Store 0xCAFE to 0x40 with despacho held through confirma, then load it back
        exp_tag.push_back(4'h8);
        issue(6'b000_100, 16'h0000, 16'h0040, 16'hCAFE, 4'h8, 10'd50, 1'b1);
        wait_op(kr, kc);
        check("t4_conf_latency", 32'(kc), 32'd3);
        @(posedge clk); #2 bus.despacho = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_no_reaccept", 32'(bus.busy), 32'd0);
        run_load("t4_load", 16'h0000, 16'h0040, 4'h9, 16'hCAFE, FWD_K);

        // Base 0xFFFF + 2 wraps to 0x0001
        run_store("t5_wrap_store", 16'h0002, 16'hFFFF, 16'h5A5A, 4'hA);
        run_load("t5_wrap_load", 16'h0000, 16'h0001, 4'hB, 16'h5A5A, FWD_K);

        // Invalid opcode: straight to DONE, no memory access
        exp_tag.push_back(4'hC);
        issue(6'b000_001, 16'h0000, 16'h0040, 16'hDEAD, 4'hC, 10'd60, 1'b0);
        wait_op(kr, kc);
        check("t6_no_req", 32'(kr), 32'hFFFF_FFFF);
        check("t6_conf_latency", 32'(kc), 32'd1);
        run_load("t6_mem_unchanged", 16'h0000, 16'h0040, 4'hD, 16'hCAFE, 3);

        repeat (4) @(negedge clk);
        check("cdb_queue_drained", 32'(exp_cdb.size()), 32'd0);
        check("tag_queue_drained", 32'(exp_tag.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
